sdp_ram_clr: RTL

//  Parametrised simple-dual-port block RAM (one write port, one read port, shared clock)

---
 rtl/sdp_ram_clr.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sdp_ram_clr.sv
// Simple-dual-port RAM with a hardware clear sequencer and a valid-qualified read path.
// Optional macro SDP_RAM_OUT_REG_EN adds a second output register (read latency 2).
module sdp_ram_clr #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_SIZE  = 1024,
    parameter int RDW_MODE  = 0,
    localparam int AW       = $clog2(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    output logic                 busy,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [MEM_WIDTH-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [MEM_WIDTH-1:0] rd_data,
    output logic                 rd_valid
);
    localparam logic [AW:0]   SIZE_W = (AW+1)'(MEM_SIZE);
    localparam logic [AW-1:0] LAST   = AW'(MEM_SIZE - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          cnt_q, cnt_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [MEM_WIDTH-1:0]   rd_data_q, rd_data_d;

    logic [MEM_WIDTH-1:0]   mem [MEM_SIZE];

    logic                   mem_we;
    logic [AW-1:0]          mem_waddr;
    logic [MEM_WIDTH-1:0]   mem_wdata;
    logic                   rd_fire;
    logic                   wr_in_range;
    logic                   rd_in_range;

    assign wr_in_range = ({1'b0, wr_addr} < SIZE_W);
    assign rd_in_range = ({1'b0, rd_addr} < SIZE_W);

    // One write site shared by the user port and the clear engine keeps the array BRAM-inferable.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        rd_fire   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    mem_we  = wr_en && wr_in_range;
                    rd_fire = rd_en;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Collision policy: write-first forwards the incoming word, read-first returns the array word.
    always_comb begin
        rd_valid_d = rd_fire;
        rd_data_d  = rd_data_q;
        if (rd_fire) begin
            if (!rd_in_range) begin
                rd_data_d = '0;
            end else if (RDW_MODE == 0 && mem_we && mem_waddr == rd_addr) begin
                rd_data_d = wr_data;
            end else begin
                rd_data_d = mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // A reset edge suppresses the write so an aborted clear stops exactly where it was.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign busy = (state_q == ST_CLEAR);

`ifdef SDP_RAM_OUT_REG_EN
    logic                 out_valid_q, out_valid_d;
    logic [MEM_WIDTH-1:0] out_data_q, out_data_d;

    always_comb begin
        out_valid_d = rd_valid_q;
        out_data_d  = rd_valid_q ? rd_data_q : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign rd_valid = out_valid_q;
    assign rd_data  = out_data_q;
`else
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`endif

endmodule
